// File: rtl/pds_pkg.sv
// Shared definitions for the pattern detect scheduler: one-hot FSM state
// encoding and the width helper used to size lane and count fields.
package pds_pkg;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_CLEAR  = 5'b00010,
        ST_RUN    = 5'b00100,
        ST_DRAIN  = 5'b01000,
        ST_REPORT = 5'b10000
    } pds_state_e;

    // Smallest w with 2**w >= value.
    function automatic int pds_clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/pds_rr_arbiter.sv
// Combinational round-robin pick: the first set request bit at or after
// the pointer, wrapping past N-1 back to 0.
module pds_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    int               w_pos;
    logic [IDX_W-1:0] w_sel;

    // Scan the lanes in priority order starting at the pointer.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = 0;
        w_sel   = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            w_sel = IDX_W'(w_pos);
            if (!o_any && i_req[w_sel]) begin
                o_any          = 1'b1;
                o_idx          = w_sel;
                o_grant[w_sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pattern_detect_scheduler.sv
// Time-shares one serial pattern detector among NUM_LANES lanes.
// A round-robin winner gets a detector clear, WINDOW_LEN enabled serial
// bits, and DET_LAT drain cycles; hits are counted and returned as
// {lane, count}.
// Optional build macro PDS_LANE_MASK_EN adds lane_mask_i (1 = lane ineligible).
//
// Result handshake: res_valid_o rises in REPORT and stays high with
// res_lane_o/res_count_o frozen until a cycle where res_ready_i=1; that
// edge is the transfer. res_ready_i outside REPORT has no effect.
module pattern_detect_scheduler
    import pds_pkg::*;
#(
    parameter  int NUM_LANES  = 4,
    parameter  int WINDOW_LEN = 16,
    parameter  int DET_LAT    = 1,
    localparam int LANE_W     = pds_clog2(NUM_LANES),
    localparam int CNT_W      = pds_clog2(WINDOW_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic [NUM_LANES-1:0] req_i,
    input  logic [NUM_LANES-1:0] serial_i,
`ifdef PDS_LANE_MASK_EN
    input  logic [NUM_LANES-1:0] lane_mask_i,
`endif
    output logic [NUM_LANES-1:0] grant_o,
    output logic                 det_clear_o,
    output logic                 det_enable_o,
    output logic                 det_serial_o,
    input  logic                 det_hit_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [LANE_W-1:0]    res_lane_o,
    output logic [CNT_W-1:0]     res_count_o,
    output logic                 busy_o,
    output pds_state_e           dbg_state_o
);

    pds_state_e           r_state;
    pds_state_e           w_next;
    logic [LANE_W-1:0]    r_ptr;
    logic [LANE_W-1:0]    r_lane;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [CNT_W-1:0]     r_hit_cnt;
    logic [1:0]           r_drain_cnt;
    logic [NUM_LANES-1:0] w_elig;
    logic [NUM_LANES-1:0] w_arb_grant;
    logic [LANE_W-1:0]    w_arb_idx;
    logic                 w_arb_any;
    logic                 w_last_bit;
    logic                 w_drain_done;
    logic                 w_run_sample;

`ifdef PDS_LANE_MASK_EN
    assign w_elig = req_i & ~lane_mask_i;
`else
    assign w_elig = req_i;
`endif

    pds_rr_arbiter #(
        .N     (NUM_LANES),
        .IDX_W (LANE_W)
    ) u_arb (
        .i_req   (w_elig),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_any   (w_arb_any)
    );

    assign w_last_bit   = (r_bit_cnt == CNT_W'(WINDOW_LEN - 1));
    assign w_drain_done = (r_drain_cnt == 2'(DET_LAT - 1));

    // The first DET_LAT hits of RUN belong to the previous detector history.
    generate
        if (DET_LAT == 0) begin : g_no_lat
            assign w_run_sample = 1'b1;
        end else begin : g_lat
            assign w_run_sample = (r_bit_cnt >= CNT_W'(DET_LAT));
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rstb) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and all externally visible outputs, decoded from state.
    always_comb begin
        w_next       = r_state;
        grant_o      = '0;
        det_clear_o  = 1'b0;
        det_enable_o = 1'b0;
        det_serial_o = 1'b0;
        res_valid_o  = 1'b0;
        res_lane_o   = '0;
        res_count_o  = '0;
        busy_o       = (r_state != ST_IDLE);
        if (r_state != ST_IDLE) begin
            grant_o[r_lane] = 1'b1;
        end
        case (r_state)
            ST_IDLE: begin
                if (w_arb_any) begin
                    w_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                det_clear_o = 1'b1;
                w_next      = ST_RUN;
            end
            ST_RUN: begin
                det_enable_o = 1'b1;
                det_serial_o = serial_i[r_lane];
                if (w_last_bit) begin
                    w_next = (DET_LAT == 0) ? ST_REPORT : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drain_done) begin
                    w_next = ST_REPORT;
                end
            end
            ST_REPORT: begin
                res_valid_o = 1'b1;
                res_lane_o  = r_lane;
                res_count_o = r_hit_cnt;
                if (res_ready_i) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Lane latch, window counters and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rstb) begin
            r_ptr       <= '0;
            r_lane      <= '0;
            r_bit_cnt   <= '0;
            r_hit_cnt   <= '0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_any) begin
                        r_lane <= w_arb_idx;
                    end
                end
                ST_CLEAR: begin
                    r_bit_cnt   <= '0;
                    r_hit_cnt   <= '0;
                    r_drain_cnt <= '0;
                end
                ST_RUN: begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (w_run_sample && det_hit_i) begin
                        r_hit_cnt <= r_hit_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    r_drain_cnt <= r_drain_cnt + 1'b1;
                    if (det_hit_i) begin
                        r_hit_cnt <= r_hit_cnt + 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (res_ready_i) begin
                        r_ptr <= (r_lane == LANE_W'(NUM_LANES - 1)) ? '0 : r_lane + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_pattern_detect_scheduler.sv
// Bench for pattern_detect_scheduler (NUM_LANES=4, WINDOW_LEN=8, DET_LAT=1).
// The bench plays the detector: it drives random hit pulses and predicts
// the count from the window timing, and predicts the granted lane from the
// round-robin rule.
module tb_pattern_detect_scheduler;
  import pds_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int L  = 1;
  localparam int LW = 2;
  localparam int CW = 4;
  localparam int RW = LW + CW;

  logic          clk;
  logic          rstb;
  logic [N-1:0]  req_i;
  logic [N-1:0]  serial_i;
  logic [N-1:0]  grant_o;
  logic          det_clear_o;
  logic          det_enable_o;
  logic          det_serial_o;
  logic          det_hit_i;
  logic          res_valid_o;
  logic          res_ready_i;
  logic [LW-1:0] res_lane_o;
  logic [CW-1:0] res_count_o;
  logic          busy_o;
  pds_state_e    dbg_state_o;
  logic [N-1:0]  mask_v;

`ifdef PDS_LANE_MASK_EN
  logic [N-1:0] lane_mask_i;
  assign lane_mask_i = mask_v;
`endif

  pattern_detect_scheduler #(
    .NUM_LANES  (N),
    .WINDOW_LEN (W),
    .DET_LAT    (L)
  ) dut (
    .clk          (clk),
    .rstb         (rstb),
    .req_i        (req_i),
    .serial_i     (serial_i),
`ifdef PDS_LANE_MASK_EN
    .lane_mask_i  (lane_mask_i),
`endif
    .grant_o      (grant_o),
    .det_clear_o  (det_clear_o),
    .det_enable_o (det_enable_o),
    .det_serial_o (det_serial_o),
    .det_hit_i    (det_hit_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_lane_o   (res_lane_o),
    .res_count_o  (res_count_o),
    .busy_o       (busy_o),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int m_ptr    = 0;
  logic [RW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round-robin reference: first eligible lane at or after the pointer.
  function automatic int rr_pick(input logic [N-1:0] elig);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (elig[idx]) return idx;
    end
    return -1;
  endfunction

  // ---------------- driver ----------------
  // Called in an IDLE cycle. Presents req, then walks the fixed window
  // schedule: cycle 1 CLEAR, 2..W+1 RUN, then L drain cycles, then REPORT.
  task automatic do_window(input logic [N-1:0] req, input int hit_pct,
                           input logic [31:0] hit_pat, input bit early,
                           input int delay, input bit drop,
                           output int got_lane, output int got_count);
    int lane;
    int cnt;
    logic [N-1:0] exp_gnt;
    logic [RW-1:0] exp_res;
    chk("idle_busy", busy_o, 0);
    chk("idle_grant", grant_o, 0);
    chk("idle_valid", res_valid_o, 0);
    lane = rr_pick(req & ~mask_v);
    exp_gnt = '0;
    if (lane >= 0) exp_gnt[lane] = 1'b1;
    req_i = req;
    res_ready_i = early;
    det_hit_i = 1'b0;
    cnt = 0;
    step();
    for (int c = 1; c <= W + L + 1; c++) begin
      chk("win_grant", grant_o, exp_gnt);
      chk("win_busy", busy_o, 1);
      chk("win_clear", det_clear_o, (c == 1));
      chk("win_enable", det_enable_o, (c >= 2 && c <= W + 1));
      chk("win_valid_low", res_valid_o, 0);
      if (drop) req_i = '0;
      serial_i = N'($urandom);
      det_hit_i = ($urandom_range(0, 99) < hit_pct) || (((hit_pat >> c) & 32'd1) != 0);
      #1;
      chk("win_serial", det_serial_o, (c >= 2 && c <= W + 1 && lane >= 0) ? serial_i[lane] : 1'b0);
      if (c >= 2 + L && c <= W + 1 + L && det_hit_i) cnt++;
      step();
    end
    det_hit_i = 1'b0;
    exp_q.push_back({LW'(lane), CW'(cnt)});
    if (!early) begin
      for (int d = 0; d < delay; d++) begin
        chk("stall_valid", res_valid_o, 1);
        chk("stall_result", {res_lane_o, res_count_o}, exp_q[0]);
        chk("stall_grant", grant_o, exp_gnt);
        step();
      end
    end
    res_ready_i = 1'b1;
    exp_res = exp_q.pop_front();
    chk("rep_valid", res_valid_o, 1);
    chk("rep_result", {res_lane_o, res_count_o}, exp_res);
    got_lane = int'(res_lane_o);
    got_count = int'(res_count_o);
    step();
    res_ready_i = 1'b0;
    m_ptr = (lane + 1) % N;
    chk("post_valid", res_valid_o, 0);
    chk("post_grant", grant_o, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int gl;
    int gc;
    int order[5];
    order = '{0, 1, 2, 3, 0};
    rstb = 1'b1;
    req_i = '0;
    serial_i = '0;
    det_hit_i = 1'b0;
    res_ready_i = 1'b0;
    mask_v = '0;
    repeat (3) step();
    rstb = 1'b0;
    chk("rst_grant", grant_o, 0);
    chk("rst_valid", res_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_enable", det_enable_o, 0);
    chk("rst_clear", det_clear_o, 0);
    chk("rst_state", dbg_state_o, ST_IDLE);

    // All lanes requesting: strict rotation starting from lane 0.
    for (int i = 0; i < 5; i++) begin
      do_window(4'b1111, 40, 32'd0, 1'b0, 0, 1'b0, gl, gc);
      chk("rr_order", gl, order[i]);
    end

    // Single lane, three hits inside the sampled span, ready held early.
    do_window(4'b0100, 0, 32'h0000_0250, 1'b1, 0, 1'b1, gl, gc);
    chk("t1_lane", gl, 2);
    chk("t1_count", gc, 3);

    // Six-cycle stall in REPORT with other lanes still requesting.
    do_window(4'b1011, 50, 32'd0, 1'b0, 6, 1'b0, gl, gc);

    // Hits every cycle, including CLEAR and the first RUN bit.
    do_window(4'b0001, 100, 32'd0, 1'b0, 1, 1'b1, gl, gc);
    chk("t4_count", gc, W);
    do_window(4'b0010, 0, 32'h0000_0006, 1'b0, 0, 1'b1, gl, gc);
    chk("t4_edge_count", gc, 0);

    // Randomized windows.
    for (int i = 0; i < 10; i++) begin
      do_window(N'($urandom_range(1, 15)), $urandom_range(0, 100), 32'd0,
                1'(($urandom_range(0, 3) == 0)), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), gl, gc);
    end

    // Reset in the middle of RUN, after the pointer has moved off lane 0.
    do_window(4'b0010, 30, 32'd0, 1'b0, 0, 1'b1, gl, gc);
    req_i = 4'b1111;
    step();
    req_i = '0;
    det_hit_i = 1'b1;
    repeat (3) step();
    rstb = 1'b1;
    step();
    rstb = 1'b0;
    det_hit_i = 1'b0;
    chk("midrst_grant", grant_o, 0);
    chk("midrst_enable", det_enable_o, 0);
    chk("midrst_serial", det_serial_o, 0);
    chk("midrst_valid", res_valid_o, 0);
    chk("midrst_lane", res_lane_o, 0);
    chk("midrst_count", res_count_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_state", dbg_state_o, ST_IDLE);
    m_ptr = 0;
    do_window(4'b1110 | 4'b0001, 0, 32'h0000_0008, 1'b0, 0, 1'b1, gl, gc);
    chk("postrst_lane", gl, 0);
    chk("postrst_count", gc, 1);

`ifdef PDS_LANE_MASK_EN
    mask_v = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      do_window(4'b0011, 50, 32'd0, 1'b0, 0, 1'b0, gl, gc);
      chk("mask_lane", gl, 0);
    end
    mask_v = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pattern_detect_scheduler.md
Name: pattern_detect_scheduler

Overview:
Time-shares one serial pattern detector among NUM_LANES serial lanes.
- Round-robin arbitration between lane requests.
- For the granted lane: clears the detector, streams a fixed WINDOW_LEN-bit window into it with enable asserted, counts detector hits, returns {lane, hit count} over a valid/ready result interface.
- Sits between the lane front-ends and the single detector instance.

Parameters:
NUM_LANES, 4, number of requesting serial lanes (2..16)
WINDOW_LEN, 16, serial bits streamed per granted window (>=1)
DET_LAT, 1, detector input-to-hit latency in cycles (0..3)
LANE_W, derived clog2(NUM_LANES), lane index width (localparam)
CNT_W, derived clog2(WINDOW_LEN+1), hit count width (localparam)

Ports:
clk  in  1  clock
rstb  in  1  reset, synchronous, active-high
req_i  in  NUM_LANES  per-lane level request for a detection window
serial_i  in  NUM_LANES  per-lane serial bit
grant_o  out  NUM_LANES  one-hot grant, high from CLEAR through REPORT handshake
det_clear_o  out  1  one-cycle detector history clear
det_enable_o  out  1  detector enable
det_serial_o  out  1  muxed serial bit to detector
det_hit_i  in  1  detector pattern-detected output
res_valid_o  out  1  result valid
res_ready_i  in  1  result accept
res_lane_o  out  LANE_W  lane index of result
res_count_o  out  CNT_W  number of hit samples in window
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset (rstb=1 at posedge):
  - state=IDLE, rr pointer=0, counters=0.
  - All outputs 0.
  - Any in-flight window is discarded; no result is produced.
- FSM states: IDLE, CLEAR, RUN, DRAIN, REPORT. One-hot encoded, registered.
- IDLE:
  - req_i is sampled only here.
  - If any bit is set, pick the first set bit at or after the pointer (wrapping), latch the lane, go to CLEAR.
- CLEAR:
  - Lasts 1 cycle.
  - det_clear_o=1, det_enable_o=0.
  - bit_cnt=0, hit_cnt=0.
- RUN:
  - Lasts exactly WINDOW_LEN cycles.
  - det_enable_o=1.
  - det_serial_o=serial_i[lane] (combinational mux, latched lane select).
  - bit_cnt increments each cycle; on the last bit go to DRAIN, or to REPORT if DET_LAT=0.
- DRAIN:
  - Lasts DET_LAT cycles.
  - det_enable_o=0, det_serial_o=0.
- Hit sampling:
  - hit_cnt increments on det_hit_i=1 in RUN cycles with bit_cnt>=DET_LAT, and in every DRAIN cycle.
  - This gives exactly WINDOW_LEN samples; max count=WINDOW_LEN, no overflow.
- REPORT:
  - res_valid_o=1.
  - res_lane_o and res_count_o are held stable until res_ready_i=1.
  - On handshake: pointer=lane+1 (wrapping at NUM_LANES), grant_o=0, go to IDLE.
  - No back-to-back grant in the handshake cycle.
- Latency: req sampled at edge T -> grant_o high at T+1 -> res_valid_o high at T+WINDOW_LEN+DET_LAT+2.
- Requests:
  - req_i deasserting after grant does not shorten the window.
  - A lane still requesting after its report is eligible again, but lower priority than the others.
- Simultaneous requests: strict round-robin from the pointer; fairness bound is NUM_LANES-1 windows.
- res_ready_i high before res_valid_o: ignored.

Optional Feature:
PDS_LANE_MASK_EN
- Defined: adds input lane_mask_i [NUM_LANES]. Masked lanes (bit=1) are ineligible in IDLE. Masking a lane after its grant has no effect on the current window.
- Undefined: port absent; all lanes eligible.

Decomposition:
- Package pds_pkg holds:
  - state encoding constants (IDLE, CLEAR, RUN, DRAIN, REPORT, one-hot);
  - a function for the clog2 width derivation.
- Sub-module pds_rr_arbiter: combinational round-robin pick.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, index, any_valid.
- Pointer register stays in the parent.

Test Plan:
1. NUM_LANES=4, WINDOW_LEN=8, DET_LAT=1. req_i=0100 at T, det_hit_i pulsed on 3 sample cycles, res_ready_i=1 -> grant_o=0100 at T+1; det_clear_o at T+1; det_enable_o T+2..T+9; res_valid_o at T+11 with lane=2, count=3.
2. req_i=1111 held for 5 windows -> grant order lanes 0,1,2,3,0; grant_o is one-hot with no overlap.
3. res_ready_i held 0 for 6 cycles in REPORT -> res_valid_o, lane and count stable; no new grant until the handshake.
4. det_hit_i=1 every cycle of the window -> count=8 (saturation boundary). det_hit_i high during CLEAR and at RUN bit 0 -> not counted.
5. rstb=1 mid-RUN -> next cycle all outputs 0, state IDLE; the next request is served from lane 0 with a fresh count.
6. PDS_LANE_MASK_EN defined, lane_mask_i=0010, req_i=0011 -> only lane 0 granted, repeatedly.
